// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C responder: FSM state encoding, bus ACK levels,
// the default device address and a small address-match helper.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      WORD_ADDR,
      WORD_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_slv_state_e;

   localparam logic       I2C_ACK            = 1'b0;
   localparam logic       I2C_NACK           = 1'b1;
   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h55;

   // First byte after START carries the 7-bit address in its upper bits.
   function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
      return addr_byte[7:1] == dev_addr;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with registered level and rise/fall flags for one I2C line.
// Optional 4-clk stability filter when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic filt;

   // Lines idle high, so everything resets to 1 to avoid a fake edge at reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] stable_cnt;

   // The filtered value follows only after four consecutive clocks of disagreement.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt       <= 1'b1;
         stable_cnt <= '0;
      end else if (s2 == filt) begin
         stable_cnt <= '0;
      end else if (stable_cnt == 2'd3) begin
         filt       <= s2;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + 2'd1;
      end
   end
`else
   always_comb filt = s2;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl  <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         lvl  <= filt;
         rise <= filt & ~lvl;
         fall <= ~filt & lvl;
      end
   end

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C responder with a byte-addressable flop memory and auto-incrementing pointer.
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables the input glitch filter in i2c_sync_edge.
module i2c_slave_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int         MEM_DEPTH  = 128,
   localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl,
   inout  wire              sda,
   output logic             busy,
   output logic             done,
   output logic [PTR_W-1:0] ptr
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_slv_state_e state, state_nxt;
   logic [2:0]       bit_cnt, cnt_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             phase, phase_nxt;
   logic             rw, rw_nxt;
   logic             sda_low, sda_low_nxt;
   logic             busy_nxt, done_nxt;
   logic [PTR_W-1:0] ptr_nxt;
   logic             mem_we;
   logic [7:0]       byte_in;
   logic [7:0]       rd_byte;
   logic [7:0]       mem [MEM_DEPTH];

   i2c_sync_edge u_scl_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (scl),
      .lvl  (scl_lvl),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sda),
      .lvl  (sda_lvl),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   assign start   = sda_fall & scl_lvl;
   assign stop    = sda_rise & scl_lvl;
   assign byte_in = {shreg[6:0], sda_lvl};
   assign rd_byte = mem[ptr];
   assign sda     = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         phase   <= 1'b0;
         rw      <= 1'b0;
         sda_low <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ptr     <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
         shreg   <= shreg_nxt;
         phase   <= phase_nxt;
         rw      <= rw_nxt;
         sda_low <= sda_low_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         ptr     <= ptr_nxt;
      end
   end

   // In ACK states 'phase' marks that our ACK is on the bus; in RD_DATA it marks the byte is loaded.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = bit_cnt;
      shreg_nxt   = shreg;
      phase_nxt   = phase;
      rw_nxt      = rw;
      sda_low_nxt = sda_low;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      ptr_nxt     = ptr;
      mem_we      = 1'b0;
      if (start) begin
         state_nxt   = DEV_ADDR;
         cnt_nxt     = '0;
         phase_nxt   = 1'b0;
         sda_low_nxt = 1'b0;
         busy_nxt    = 1'b0;
      end else if (stop) begin
         state_nxt   = IDLE;
         phase_nxt   = 1'b0;
         sda_low_nxt = 1'b0;
         busy_nxt    = 1'b0;
         done_nxt    = busy;
      end else begin
         case (state)
            DEV_ADDR: begin
               if (scl_rise) begin
                  shreg_nxt = byte_in;
                  cnt_nxt   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw_nxt    = byte_in[0];
                     phase_nxt = 1'b0;
                     state_nxt = addr_match(byte_in, SLAVE_ADDR) ? DEV_ACK : WAIT_STOP;
                  end
               end
            end
            DEV_ACK: begin
               if (scl_fall && !phase) begin
                  sda_low_nxt = 1'b1;
                  busy_nxt    = 1'b1;
                  phase_nxt   = 1'b1;
               end else if (scl_rise && phase && rw) begin
                  state_nxt = RD_DATA;
                  phase_nxt = 1'b0;
               end else if (scl_fall && phase && !rw) begin
                  sda_low_nxt = 1'b0;
                  phase_nxt   = 1'b0;
                  state_nxt   = WORD_ADDR;
               end
            end
            WORD_ADDR: begin
               if (scl_rise) begin
                  shreg_nxt = byte_in;
                  cnt_nxt   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr_nxt   = byte_in[PTR_W-1:0];
                     phase_nxt = 1'b0;
                     state_nxt = WORD_ACK;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shreg_nxt = byte_in;
                  cnt_nxt   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     mem_we    = 1'b1;
                     ptr_nxt   = ptr + PTR_W'(1);
                     phase_nxt = 1'b0;
                     state_nxt = WR_ACK;
                  end
               end
            end
            WORD_ACK, WR_ACK: begin
               if (scl_fall && !phase) begin
                  sda_low_nxt = 1'b1;
                  phase_nxt   = 1'b1;
               end else if (scl_fall && phase) begin
                  sda_low_nxt = 1'b0;
                  phase_nxt   = 1'b0;
                  state_nxt   = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_fall && !phase) begin
                  shreg_nxt   = rd_byte;
                  sda_low_nxt = ~rd_byte[7];
                  phase_nxt   = 1'b1;
               end else if (scl_fall && phase) begin
                  shreg_nxt   = {shreg[6:0], 1'b0};
                  sda_low_nxt = ~shreg[6];
               end else if (scl_rise && phase) begin
                  cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr_nxt   = ptr + PTR_W'(1);
                     phase_nxt = 1'b0;
                     state_nxt = RD_ACK;
                  end
               end
            end
            RD_ACK: begin
               if (scl_fall && !phase) begin
                  sda_low_nxt = 1'b0;
                  phase_nxt   = 1'b1;
               end else if (scl_rise && phase) begin
                  phase_nxt = 1'b0;
                  if (sda_lvl == I2C_NACK) begin
                     busy_nxt  = 1'b0;
                     state_nxt = WAIT_STOP;
                  end else begin
                     state_nxt = RD_DATA;
                  end
               end
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         mem[ptr] <= byte_in;
      end
   end

endmodule

// File: doc/i2c_slave_mem.md
# i2c_slave_mem

I2C responder with an internal byte-addressable register memory. It sits on the same `sda`/`scl` bus as the I2C master, oversampled by the shared system clock. It answers one 7-bit device address and supports random write, sequential write, current-address read and sequential read with auto-increment.

## Interface
- `SLAVE_ADDR`, 7'h55, device address matched against the first byte after START.
- `MEM_DEPTH`, 128, bytes of memory; must be a power of two ≤ 256. `PTR_W = $clog2(MEM_DEPTH)`.
- `clk`  input  1  system clock (50 MHz nominal; `scl` ≤ 100 kHz, so ≥ 250 clk per scl phase).
- `rst`  input  1  asynchronous, active-low reset.
- `scl`  input  1  I2C clock from the master; never driven by this block.
- `sda`  inout  1  open-drain data; driven only to 0, otherwise `1'bz`.
- `busy`  output  1  high from the ACK of a matched address until STOP, repeated START or read NACK.
- `done`  output  1  one-cycle pulse on STOP that ends an addressed transaction.
- `ptr`  output  PTR_W  current memory pointer, for debug and verification.

## Operation
- Inputs pass through a 2-flop synchronizer. Edges are derived from the synchronized values: `scl_rise`, `scl_fall`, `start` (sda falls while scl high), `stop` (sda rises while scl high).
- `start` and `stop` override every state:
  - `start` → DEV_ADDR with the bit counter cleared.
  - `stop` → IDLE, release sda, drop `busy`, pulse `done` if `busy` was high.
- Bits are sampled on `scl_rise`, MSB first. The slave changes sda only on `scl_fall`.
- States:
  - IDLE: waits for START.
  - DEV_ADDR: shifts 8 bits.
  - DEV_ACK: if addr[7:1]==SLAVE_ADDR, drive 0 for one scl period, then go to WORD_ADDR (rw=0) or RD_DATA (rw=1). On mismatch, go to WAIT_STOP with sda released.
  - WORD_ADDR: shifts 8 bits, loads `ptr` with byte[PTR_W-1:0] (upper bits ignored), then WORD_ACK.
  - WORD_ACK: drive 0, then WR_DATA.
  - WR_DATA: shifts 8 bits, writes mem[ptr], increments `ptr`, then WR_ACK.
  - WR_ACK: drive 0, then WR_DATA.
  - RD_DATA: loads mem[ptr] at the first `scl_fall`, shifts it out, increments `ptr` after bit 0, then RD_ACK.
  - RD_ACK: releases sda and samples the master's bit. ACK(0) → RD_DATA. NACK(1) → WAIT_STOP and drop `busy`.
  - WAIT_STOP: sda released; waits for START or STOP.
- `ptr` wraps from MEM_DEPTH-1 to 0. It persists across transactions, so a current-address read starts where the last access ended.
- A partial byte (STOP or START mid-byte) is discarded. No memory write and no `ptr` change.

## Timing
- Reset values: sda released (z), `busy`=0, `done`=0, `ptr`=0, state IDLE, all memory bytes 0.
- Detection latency is 3 clk from pin to edge flag, and sda update is 1 clk after `scl_fall`. That gives sda output valid ≤ 4 clk after the pin scl falls, well inside the low phase.
- The memory write occurs on the clk after the 8th `scl_rise` of a data byte.
- An ACK is held from the `scl_fall` ending bit 8 until the next `scl_fall`.
- START and STOP in the same clk cannot occur (sda changes once); START has priority if a glitch produces both.
- Reset asserted mid-transaction releases sda immediately (async) and abandons the transfer.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: after the synchronizer, the filtered scl/sda change only when the raw value is stable for 4 consecutive clk. This adds 4 clk of latency and suppresses pulses < 4 clk.
- Undefined: synchronizer output is used directly.

## Structure
- `i2c_pkg` holds:
  - the state enum `i2c_slv_state_e`;
  - `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1;
  - the default `SLAVE_ADDR`.
- Sub-module `i2c_sync_edge`: synchronizer, optional filter and rise/fall flags. It is instantiated once for scl and once for sda.
- Memory is a flop array inside `i2c_slave_mem`.

## Test plan
- Random write: START, 0xAA (0x55,W), 0x10, 0x0F, STOP → three ACKs, mem[0x10]=0x0F, `done` pulses once, `ptr`=0x11.
- Random read: START, 0xAA, 0x10, repeated START, 0xAB, read 1 byte, master NACK, STOP → slave drives 0x0F, `busy` drops at NACK, `ptr`=0x11.
- Sequential write wrap: write word addr 0x7F, data 0x11, 0x22, 0x33 → mem[0x7F]=0x11, mem[0x00]=0x22, mem[0x01]=0x33, `ptr`=0x02.
- Address mismatch: START, 0x46 (0x23,W), 0x10, 0x99, STOP → sda never driven, memory unchanged, `busy`/`done` stay 0.
- Abort: STOP after 5 bits of data byte 0xC3 at ptr 0x20 → mem[0x20] unchanged, `ptr`=0x20, state IDLE.
- Reset mid-read: assert `rst`=0 while the slave drives a 0 bit → sda goes z within the same cycle, `ptr`=0, and memory is cleared.
